// File: rtl/video_fetcher.sv
// video_fetcher: Wishbone master that bursts one scanline of playfield
//   halfwords from a running frame pointer into the CGIA line-buffer store port.
// Latency: bus cycle opens on the edge that accepts VFEN_I; each ACK'd halfword
//   is written to the line buffer in the cycle after its ACK edge.
// Backpressure: MST_ACK_I stalls the burst indefinitely; VFEN_I while busy is
//   dropped and flagged on the sticky OVR_O.
//
// Ports:
//   CLK_I, RST_I         clock, synchronous active-high reset
//   VFEN_I, VSYNC_I      line-start / frame-start strobes (one cycle wide)
//   BASE_I, LEN_I        frame base halfword address, halfwords per line
//   MST_*                Wishbone master read port (CYC == STB)
//   S_ADR_O/S_DAT_O/S_WE_O  line-buffer store port
//   BUSY_O, OVR_O        fetch in progress, sticky dropped-line flag
module video_fetcher (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        VFEN_I,
  input  logic        VSYNC_I,
  input  logic [22:0] BASE_I,
  input  logic [6:0]  LEN_I,
  output logic [22:0] MST_ADR_O,
  output logic        MST_CYC_O,
  output logic        MST_STB_O,
  input  logic        MST_ACK_I,
  input  logic [15:0] MST_DAT_I,
  output logic [5:0]  S_ADR_O,
  output logic [15:0] S_DAT_O,
  output logic        S_WE_O,
  output logic        BUSY_O,
  output logic        OVR_O
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t      state;
  logic [22:0] ptr;
  logic [6:0]  len_q;
  logic [6:0]  beat;
  logic        reload_pend;
  logic        start_pend;   // line accepted on a reload edge, starts next edge
  logic [6:0]  len_c;
  logic        reload_now;

  // A line never exceeds the 64-slot line buffer.
  assign len_c      = (LEN_I > 7'd64) ? 7'd64 : LEN_I;
  // In IDLE a fresh VSYNC_I is applied immediately, same as a deferred one.
  assign reload_now = reload_pend | VSYNC_I;

  assign MST_ADR_O = ptr;
  assign MST_CYC_O = (state == FETCH);
  assign MST_STB_O = (state == FETCH);
  assign BUSY_O    = (state == FETCH);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state       <= IDLE;
      ptr         <= 23'd0;
      len_q       <= 7'd0;
      beat        <= 7'd0;
      reload_pend <= 1'b0;
      start_pend  <= 1'b0;
      S_ADR_O     <= 6'd0;
      S_DAT_O     <= 16'd0;
      S_WE_O      <= 1'b0;
      OVR_O       <= 1'b0;
    end else begin
      S_WE_O <= 1'b0;
      case (state)
        IDLE: begin
          if (reload_now) begin
            ptr         <= BASE_I;
            reload_pend <= 1'b0;
          end
          if (start_pend) begin
            // Line deferred behind a reload: it now fetches from BASE_I.
            start_pend <= 1'b0;
            beat       <= 7'd0;
            state      <= FETCH;
            if (VFEN_I) OVR_O <= 1'b1;
          end else if (VFEN_I && (len_c != 7'd0)) begin
            len_q <= len_c;
            beat  <= 7'd0;
            if (reload_now) start_pend <= 1'b1;
            else            state      <= FETCH;
          end
        end
        FETCH: begin
          // A frame restart never splits the current line.
          if (VSYNC_I) reload_pend <= 1'b1;
          if (VFEN_I)  OVR_O       <= 1'b1;
          if (MST_ACK_I) begin
            S_DAT_O <= MST_DAT_I;
            S_ADR_O <= beat[5:0];
            S_WE_O  <= 1'b1;
            ptr     <= ptr + 23'd1;
            beat    <= beat + 7'd1;
            if (beat == len_q - 7'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_fetcher.sv
// tb_video_fetcher: randomized line fetches checked against a scoreboard of
//   expected addresses, line-buffer writes and pointer/overrun state.
module tb_video_fetcher;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        VFEN_I;
  logic        VSYNC_I;
  logic [22:0] BASE_I;
  logic [6:0]  LEN_I;
  logic [22:0] MST_ADR_O;
  logic        MST_CYC_O;
  logic        MST_STB_O;
  logic        MST_ACK_I;
  logic [15:0] MST_DAT_I;
  logic [5:0]  S_ADR_O;
  logic [15:0] S_DAT_O;
  logic        S_WE_O;
  logic        BUSY_O;
  logic        OVR_O;

  video_fetcher dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .VFEN_I(VFEN_I), .VSYNC_I(VSYNC_I),
    .BASE_I(BASE_I), .LEN_I(LEN_I), .MST_ADR_O(MST_ADR_O),
    .MST_CYC_O(MST_CYC_O), .MST_STB_O(MST_STB_O), .MST_ACK_I(MST_ACK_I),
    .MST_DAT_I(MST_DAT_I), .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O),
    .S_WE_O(S_WE_O), .BUSY_O(BUSY_O), .OVR_O(OVR_O)
  );

  always #5 CLK_I = ~CLK_I;

  int checks = 0;
  int failures = 0;

  // Reference state: where the next line must start, and the overrun flag.
  logic [22:0] exp_ptr = 23'd0;
  bit          ovr_exp = 1'b0;
  bit          vs_pend = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic vsync(input logic [22:0] b);
    @(negedge CLK_I);
    BASE_I  = b;
    VSYNC_I = 1'b1;
    @(posedge CLK_I);
    @(negedge CLK_I);
    VSYNC_I = 1'b0;
    exp_ptr = b;
    check_eq("vsync_adr", MST_ADR_O, exp_ptr);
  endtask

  // One line: optional stalls, mid-burst VSYNC/VFEN, reset at a beat, or
  // VSYNC on the same edge as the accepted VFEN.
  task automatic run_line(input int len, input bit stall, input int vs_beat,
                          input logic [22:0] vs_base, input int fen_beat,
                          input int rst_beat, input bit sync_start,
                          input logic [22:0] sync_base);
    int n, beat, cycles, writes, prev_slot;
    bit ack, prev_ack, vs_done, fen_done;
    logic [15:0] dat, prev_dat;
    n = (len > 64) ? 64 : len;
    beat = 0; cycles = 0; writes = 0; prev_slot = 0;
    prev_ack = 1'b0; vs_done = 1'b0; fen_done = 1'b0; prev_dat = 16'd0;
    @(negedge CLK_I);
    VFEN_I = 1'b1;
    LEN_I  = len[6:0];
    if (sync_start) begin
      VSYNC_I = 1'b1;
      BASE_I  = sync_base;
    end
    @(posedge CLK_I);
    if (sync_start) exp_ptr = sync_base;
    @(negedge CLK_I);
    VFEN_I  = 1'b0;
    VSYNC_I = 1'b0;
    if (n == 0) begin
      check_eq("zero_len_busy", BUSY_O, 0);
      check_eq("zero_len_adr", MST_ADR_O, exp_ptr);
      return;
    end
    if (sync_start) begin
      check_eq("sync_wait_busy", BUSY_O, 0);
      check_eq("sync_adr", MST_ADR_O, exp_ptr);
      @(negedge CLK_I);
    end
    while (beat < n && cycles < 1000) begin
      check_eq("cyc", MST_CYC_O, 1);
      check_eq("stb", MST_STB_O, 1);
      check_eq("busy", BUSY_O, 1);
      check_eq("adr", MST_ADR_O, exp_ptr);
      check_eq("we", S_WE_O, prev_ack);
      if (prev_ack) begin
        check_eq("slot", S_ADR_O, prev_slot);
        check_eq("data", S_DAT_O, prev_dat);
        writes++;
      end
      if (beat == rst_beat) RST_I = 1'b1;
      ack = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      dat = 16'($urandom);
      MST_ACK_I = ack;
      MST_DAT_I = dat;
      if (beat == vs_beat && !vs_done) begin
        VSYNC_I = 1'b1;
        BASE_I  = vs_base;
        vs_done = 1'b1;
        vs_pend = 1'b1;
      end
      if (beat == fen_beat && !fen_done) begin
        VFEN_I   = 1'b1;
        LEN_I    = 7'($urandom_range(1, 100));
        fen_done = 1'b1;
        ovr_exp  = 1'b1;
      end
      @(posedge CLK_I);
      cycles++;
      prev_ack = ack;
      if (ack) begin
        prev_slot = beat;
        prev_dat  = dat;
        beat++;
        exp_ptr = exp_ptr + 23'd1;
      end
      @(negedge CLK_I);
      MST_ACK_I = 1'b0;
      VSYNC_I   = 1'b0;
      VFEN_I    = 1'b0;
      if (RST_I) begin
        RST_I = 1'b0;
        exp_ptr = 23'd0;
        ovr_exp = 1'b0;
        vs_pend = 1'b0;
        check_eq("rst_cyc", MST_CYC_O, 0);
        check_eq("rst_we", S_WE_O, 0);
        check_eq("rst_busy", BUSY_O, 0);
        check_eq("rst_ptr", MST_ADR_O, 0);
        check_eq("rst_ovr", OVR_O, 0);
        return;
      end
    end
    if (beat < n) check_eq("line_timeout", beat, n);
    check_eq("end_cyc", MST_CYC_O, 0);
    check_eq("end_busy", BUSY_O, 0);
    check_eq("we_last", S_WE_O, prev_ack);
    if (prev_ack) begin
      check_eq("slot_last", S_ADR_O, prev_slot);
      check_eq("data_last", S_DAT_O, prev_dat);
      writes++;
    end
    if (!stall) check_eq("bus_cycles", cycles, n);
    @(negedge CLK_I);
    check_eq("we_off", S_WE_O, 0);
    check_eq("writes", writes, n);
    if (vs_pend) begin
      exp_ptr = vs_base;
      vs_pend = 1'b0;
    end
    check_eq("ptr_after", MST_ADR_O, exp_ptr);
    check_eq("ovr", OVR_O, ovr_exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_I = 1'b1; VFEN_I = 1'b0; VSYNC_I = 1'b0; BASE_I = 23'd0;
    LEN_I = 7'd0; MST_ACK_I = 1'b0; MST_DAT_I = 16'd0;
    repeat (2) @(posedge CLK_I);
    @(negedge CLK_I);
    RST_I = 1'b0;
    check_eq("reset_cyc", MST_CYC_O, 0);
    check_eq("reset_stb", MST_STB_O, 0);
    check_eq("reset_adr", MST_ADR_O, 0);
    check_eq("reset_we", S_WE_O, 0);
    check_eq("reset_slot", S_ADR_O, 0);
    check_eq("reset_dat", S_DAT_O, 0);
    check_eq("reset_busy", BUSY_O, 0);
    check_eq("reset_ovr", OVR_O, 0);

    // Frame start then two contiguous zero-wait lines.
    vsync(23'h000100);
    run_line(4, 1'b0, -1, 23'd0, -1, -1, 1'b0, 23'd0);
    run_line(4, 1'b0, -1, 23'd0, -1, -1, 1'b0, 23'd0);
    // Oversize line with stalls clamps to 64 writes.
    run_line(100, 1'b1, -1, 23'd0, -1, -1, 1'b0, 23'd0);
    // Zero length is ignored.
    run_line(0, 1'b0, -1, 23'd0, -1, -1, 1'b0, 23'd0);
    // Mid-burst VSYNC and VFEN, then the next line starts at the new base.
    run_line(20, 1'b1, 5, 23'h002000, 8, -1, 1'b0, 23'd0);
    run_line(4, 1'b0, -1, 23'd0, -1, -1, 1'b0, 23'd0);
    // Pointer wrap.
    vsync(23'h7FFFFE);
    run_line(4, 1'b0, -1, 23'd0, -1, -1, 1'b0, 23'd0);
    // VSYNC coincident with VFEN: line fetches from the new base.
    run_line(3, 1'b0, -1, 23'd0, -1, -1, 1'b1, 23'h000300);
    // Random lines.
    for (int i = 0; i < 8; i++)
      run_line(int'($urandom_range(0, 100)), 1'($urandom_range(0, 1)),
               -1, 23'd0, -1, -1, 1'b0, 23'd0);
    // Reset at beat 2 of an 8-beat line, then a clean line from pointer 0.
    run_line(8, 1'b0, -1, 23'd0, -1, 2, 1'b0, 23'd0);
    run_line(5, 1'b1, -1, 23'd0, -1, -1, 1'b0, 23'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_fetcher.md
# video_fetcher

Wishbone bus master that fetches one scanline of playfield halfwords from video memory per line and writes them into the CGIA scanline buffers through their store port. On each line-start strobe it bursts `LEN_I` halfwords from a running frame pointer. Each halfword is written to consecutive line-buffer slots starting at 0. The buffer that the refresh circuit is not displaying receives the data. A vertical-sync strobe rewinds the pointer to the frame base.

## Interface
Parameters: none. All widths are fixed.

- `CLK_I` in 1: Wishbone SYSCON clock; shared with the line buffers.
- `RST_I` in 1: reset; synchronous, active-high.
- `VFEN_I` in 1: line-start strobe from the CRTC, one cycle wide.
- `VSYNC_I` in 1: frame-start strobe, one cycle wide.
- `BASE_I` in 23: halfword address of the frame start. Sampled only when the pointer reload is applied.
- `LEN_I` in 7: halfwords per line. Sampled on an accepted `VFEN_I`. 0 means no fetch; values above 64 clamp to 64.
- `MST_ADR_O` out 23: halfword fetch address.
- `MST_CYC_O`, `MST_STB_O` out 1: bus cycle and strobe; always equal.
- `MST_ACK_I` in 1: transfer acknowledge.
- `MST_DAT_I` in 16: read data.
- `S_ADR_O` out 6: line-buffer slot; drives the buffers' `S_ADR_I`.
- `S_DAT_O` out 16: drives `S_DAT_I`.
- `S_WE_O` out 1: drives `S_WE_I`.
- `BUSY_O` out 1: high while in the FETCH state.
- `OVR_O` out 1: sticky overrun flag; cleared only by reset.

## Operation
- State IDLE:
  - `MST_CYC_O`/`MST_STB_O` are 0.
  - If `VFEN_I`=1 and the clamped length is non-zero: latch the length, clear the beat counter, go to FETCH.
  - `VFEN_I` with a length of 0 is ignored and the pointer does not move.
- State FETCH:
  - `MST_CYC_O`=`MST_STB_O`=1 and `MST_ADR_O`=pointer.
  - Each cycle with `MST_ACK_I`=1 registers:
    - `S_DAT_O` ← `MST_DAT_I`
    - `S_ADR_O` ← beat counter (low 6 bits)
    - `S_WE_O` ← 1
  - On that same edge the pointer and the beat counter each increment.
  - When the acknowledged beat is the last one (counter = length−1), the block returns to IDLE on that edge.
- `S_WE_O` is 0 in every cycle not immediately following an ACK edge.
- Pointer: 23-bit register that wraps from 0x7FFFFF to 0x000000. It carries over between lines, so consecutive lines fetch contiguous memory.
- `VSYNC_I` sets a reload-pending flag.
  - In IDLE, the pending reload is applied on the next edge: pointer ← `BASE_I`, flag cleared.
  - In FETCH, the reload waits until the cycle after the return to IDLE. The current line is never split.
- `VFEN_I` and `VSYNC_I` on the same edge in IDLE: the reload takes priority. The fetch starts on the edge after the reload, and that line fetches from `BASE_I`.
- `VFEN_I` while in FETCH is ignored and sets `OVR_O`=1.
- The block never asserts `S_WE_O` more than 64 times per accepted strobe, so the line buffers cannot overflow.

## Timing
- Reset values: `MST_CYC_O`=`MST_STB_O`=0, `MST_ADR_O`=0, `S_WE_O`=0, `S_ADR_O`=0, `S_DAT_O`=0, `BUSY_O`=0, `OVR_O`=0. The pointer and the reload flag are also cleared.
- Reset while in FETCH: the bus cycle drops on the reset edge, with no further `S_WE_O`. The slave must tolerate the abandoned cycle.
- `VFEN_I` sampled at edge k: `MST_CYC_O` and `BUSY_O` are high from edge k onward (first bus cycle is k+1).
- `MST_ACK_I` sampled at edge m: `S_WE_O` is high for exactly the cycle after m. The line buffer stores the data at edge m+1.
- Throughput is one halfword per cycle under continuous ACK. A line of length N with zero wait states occupies N bus cycles.
- The last ACK at edge m: `MST_CYC_O` and `BUSY_O` are low from m onward. The next `VFEN_I` can be accepted at edge m+1.
- The fetch must finish before the CRTC toggles `ODD_I`. The CRTC guarantees this budget; the fetcher does not check it.

## Test plan
- Reset, then `BASE_I`=0x000100, pulse `VSYNC_I`, then `VFEN_I` with `LEN_I`=4, zero-wait ACK. Required: addresses 0x100–0x103; `S_WE_O` high for 4 cycles with `S_ADR_O` 0–3 and the matching data; `BUSY_O` high for 4 cycles.
- A second `VFEN_I` with `LEN_I`=4 and no `VSYNC_I`. Required: addresses 0x104–0x107; `S_ADR_O` restarts at 0.
- `LEN_I`=100 with random ACK stalls. Required: exactly 64 writes, slots 0–63, and the pointer advances by 64.
- `VSYNC_I` pulsed mid-burst with `BASE_I`=0x2000. Required: the current line completes at the old addresses; the next line starts at 0x2000. `VFEN_I` pulsed mid-burst: `OVR_O`=1 and the burst is unaffected.
- Pointer at 0x7FFFFE, `LEN_I`=4. Required: addresses 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
- Assert `RST_I` at beat 2 of an 8-beat line. Required: the next cycle shows `MST_CYC_O`=0, `S_WE_O`=0, `BUSY_O`=0, and the pointer = 0.
